// File: rtl/splash_pkg.sv
// splash_pkg: image-select enum, colours, text-window geometry and 5x7 font shared by the splash painter
package splash_pkg;
  typedef enum logic [1:0] {IMG_NONE, IMG_TITLE, IMG_GAMEOVER, IMG_BLACK} img_t;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_TITLE = 3'b010;
  localparam logic [2:0] COL_GAMEOVER = 3'b100;
  localparam logic [2:0] COL_BORDER = 3'b111;
  localparam int WIN_X0 = 48;
  localparam int WIN_Y0 = 52;
  localparam int WIN_W = 64;
  localparam int WIN_H = 16;
  function automatic logic [34:0] font(input logic [3:0] ch);
    case (ch)
      4'd1: font = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110};
      4'd2: font = {5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001, 5'b10001};
      4'd3: font = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
      4'd4: font = {5'b10001, 5'b10010, 5'b10100, 5'b11000, 5'b10100, 5'b10010, 5'b10001};
      4'd5: font = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
      4'd6: font = {5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01111};
      4'd7: font = {5'b10001, 5'b11011, 5'b10101, 5'b10101, 5'b10001, 5'b10001, 5'b10001};
      4'd8: font = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
      4'd9: font = {5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01010, 5'b00100};
      4'd10: font = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b10010, 5'b10001};
      default: font = '0;
    endcase
  endfunction
endpackage

// File: rtl/splash_glyph_rom.sv
// splash_glyph_rom: combinational 2048x1 bitmap, bank 1 "SNAKE", bank 0 "GAME OVER", addr = {bank, row[3:0], col[5:0]}
module splash_glyph_rom
  import splash_pkg::*;
(
  input  logic [10:0] addr,
  output logic        pix
);
  localparam logic [35:0] TXT_GAMEOVER = {4'd6, 4'd3, 4'd7, 4'd5, 4'd0, 4'd8, 4'd9, 4'd5, 4'd10};
  localparam logic [35:0] TXT_TITLE = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 16'd0};
  localparam int ORG_TITLE = 17;
  localparam int ORG_GAMEOVER = 5;
  localparam int PITCH = 6;
  localparam int ROW0 = 4;
  function automatic logic lookup(input logic bank, input logic [3:0] row, input logic [5:0] col);
    logic [34:0] f;
    int c0, r, cx;
    lookup = 1'b0;
    r = int'(row) - ROW0;
    for (int i = 0; i < 9; i++) begin
      c0 = (bank ? ORG_TITLE : ORG_GAMEOVER) + PITCH * i;
      cx = int'(col) - c0;
      f = font(bank ? TXT_TITLE[35-4*i -: 4] : TXT_GAMEOVER[35-4*i -: 4]);
      if (r >= 0 && r < 7 && cx >= 0 && cx < 5) lookup = f[34 - 5*r - cx];
    end
  endfunction
  assign pix = lookup(addr[10], addr[9:6], addr[5:0]);
endmodule

// File: rtl/splash_painter.sv
// splash_painter: sweeps the 160x120 framebuffer once per newly selected image (title/game-over/black), one plot per cycle then done; SPLASH_BORDER_EN adds a white frame
module splash_painter
  import splash_pkg::*;
#(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       showTitle,
  input  logic       showGameOver,
  input  logic       drawBlack,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  img_t sel, sel_q, img_q, img_d;
  logic [1:0] state_q, state_d;
  logic [7:0] cx_q, cx_d, x_q, x_d, dx;
  logic [6:0] cy_q, cy_d, y_q, y_d, dy;
  logic [2:0] colour_q, colour_d, fg, pix_col;
  logic plot_q, plot_d, done_q, done_d;
  logic trig, last_x, last, in_win, border, gbit;
  assign sel = drawBlack ? IMG_BLACK : showGameOver ? IMG_GAMEOVER : showTitle ? IMG_TITLE : IMG_NONE;
  assign trig = sel != sel_q && sel != IMG_NONE;
  assign last_x = cx_q == 8'(WIDTH - 1);
  assign last = last_x && cy_q == 7'(HEIGHT - 1);
  assign dx = cx_q - 8'(WIN_X0);
  assign dy = cy_q - 7'(WIN_Y0);
  assign in_win = dx < 8'(WIN_W) && dy < 7'(WIN_H);
  splash_glyph_rom u_rom (.addr({img_q[0], dy[3:0], dx[5:0]}), .pix(gbit));
`ifdef SPLASH_BORDER_EN
  assign border = img_q != IMG_BLACK && (cx_q == 8'd0 || last_x || cy_q == 7'd0 || cy_q == 7'(HEIGHT - 1));
`else
  assign border = 1'b0;
`endif
  assign fg = img_q == IMG_GAMEOVER ? COL_GAMEOVER : COL_TITLE;
  assign pix_col = img_q == IMG_BLACK ? COL_BLACK : border ? COL_BORDER : in_win && gbit ? fg : COL_BLACK;
  always_comb begin
    state_d = state_q;
    img_d = img_q;
    cx_d = cx_q;
    cy_d = cy_q;
    x_d = x_q;
    y_d = y_q;
    colour_d = colour_q;
    plot_d = 1'b0;
    done_d = state_q == S_FINISH;
    if (trig) begin
      state_d = S_SWEEP;
      img_d = sel;
      cx_d = '0;
      cy_d = '0;
    end else if (state_q == S_SWEEP && sel == IMG_NONE) begin
      state_d = S_IDLE;
    end else if (state_q == S_SWEEP) begin
      plot_d = 1'b1;
      x_d = cx_q;
      y_d = cy_q;
      colour_d = pix_col;
      cx_d = last_x ? 8'd0 : cx_q + 8'd1;
      cy_d = last_x ? cy_q + 7'd1 : cy_q;
      state_d = last ? S_FINISH : S_SWEEP;
    end else if (state_q == S_FINISH) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q <= IMG_NONE;
      img_q <= IMG_NONE;
      cx_q <= '0;
      cy_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
      plot_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel;
      img_q <= img_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
      plot_q <= plot_d;
      done_q <= done_d;
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign colour = colour_q;
  assign plot = plot_q;
  assign busy = plot_q;
  assign done = done_q;
endmodule

// File: tb/tb_splash_painter.sv
// tb_splash_painter: directed self-checking bench for splash_painter sweeps, priority, retarget, abort, glyphs and reset
module tb_splash_painter;
  logic clk = 1'b0, rst = 1'b1, show_title = 1'b0, show_game_over = 1'b0, draw_black = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, busy, done;
  logic [2:0] cbuf [19200];
  int checks = 0, errors = 0;
`ifdef SPLASH_BORDER_EN
  localparam logic [2:0] EDGE_COL = 3'b111;
`else
  localparam logic [2:0] EDGE_COL = 3'b000;
`endif
  always #5 clk = ~clk;
  splash_painter dut (
    .clk(clk), .rst(rst), .showTitle(show_title), .showGameOver(show_game_over), .drawBlack(draw_black),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );
  function automatic int pidx(input int px, input int py);
    return py * 160 + px;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_flags();
    show_title = 1'b0;
    show_game_over = 1'b0;
    draw_black = 1'b0;
    repeat (3) tick();
  endtask
  task automatic count_plots(input int target, output int k, output int dones);
    k = 0;
    dones = 0;
    for (int c = 0; c < target + 100 && k < target; c++) begin
      tick();
      if (plot) k++;
      if (done) dones++;
    end
  endtask
  task automatic capture_sweep(input int lim, output int n, output int fc, output int dc, output int ob);
    n = 0;
    fc = -1;
    dc = -1;
    ob = 0;
    for (int c = 1; c <= 20000; c++) begin
      tick();
      if (busy !== plot) ob++;
      if (done) begin
        dc = c;
        if (plot) ob++;
        break;
      end
      if (plot) begin
        if (fc < 0) fc = c;
        if (n < 19200) begin
          if (x !== 8'(n % 160) || y !== 7'(n / 160)) ob++;
          cbuf[n] = colour;
        end
        n++;
        if (n == lim) break;
      end else if (n > 0) break;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_strobes: plot/busy/done=%b%b%b, expected 000", plot, busy, done); end
    checks++; if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin errors++; $display("FAIL reset_pixel: x=%0d y=%0d colour=%b, expected 0 0 000", x, y, colour); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_title();
    int n, fc, dc, ob, fgc, bad;
    show_title = 1'b1;
    capture_sweep(0, n, fc, dc, ob);
    checks++; if (fc !== 2) begin errors++; $display("FAIL title_first_plot: cycle %0d, expected 2", fc); end
    checks++; if (n !== 19200) begin errors++; $display("FAIL title_plots: %0d, expected 19200", n); end
    checks++; if (dc !== 19202) begin errors++; $display("FAIL title_done: cycle %0d, expected 19202", dc); end
    checks++; if (ob !== 0) begin errors++; $display("FAIL title_raster: %0d order/busy errors, expected 0", ob); end
    checks++; if (cbuf[pidx(66, 56)] !== 3'b010) begin errors++; $display("FAIL title_s_on: %b, expected 010", cbuf[pidx(66, 56)]); end
    checks++; if (cbuf[pidx(65, 56)] !== 3'b000) begin errors++; $display("FAIL title_s_off: %b, expected 000", cbuf[pidx(65, 56)]); end
    checks++; if (cbuf[pidx(73, 58)] !== 3'b010 || cbuf[pidx(72, 58)] !== 3'b000) begin errors++; $display("FAIL title_n: %b %b, expected 010 000", cbuf[pidx(73, 58)], cbuf[pidx(72, 58)]); end
    checks++; if (cbuf[pidx(93, 62)] !== 3'b010) begin errors++; $display("FAIL title_e: %b, expected 010", cbuf[pidx(93, 62)]); end
    fgc = 0;
    for (int k = 0; k < 19200; k++) if (cbuf[k] === 3'b010) fgc++;
    checks++; if (fgc !== 82) begin errors++; $display("FAIL title_fg_count: %0d, expected 82", fgc); end
    bad = 0;
    repeat (40) begin
      tick();
      if (plot || done || busy) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL title_no_retrigger: %0d active cycles, expected 0", bad); end
  endtask
  task automatic test_black();
    int n, fc, dc, ob, nz;
    idle_flags();
    draw_black = 1'b1;
    show_game_over = 1'b1;
    capture_sweep(0, n, fc, dc, ob);
    nz = 0;
    for (int k = 0; k < 19200; k++) if (cbuf[k] !== 3'b000) nz++;
    checks++; if (n !== 19200 || dc !== 19202) begin errors++; $display("FAIL black_sweep: plots=%0d done_cycle=%0d, expected 19200 19202", n, dc); end
    checks++; if (nz !== 0) begin errors++; $display("FAIL black_colour: %0d non-black pixels, expected 0", nz); end
  endtask
  task automatic test_retarget();
    int k, dn, n, fc, dc, ob;
    idle_flags();
    show_title = 1'b1;
    count_plots(5000, k, dn);
    show_game_over = 1'b1;
    capture_sweep(0, n, fc, dc, ob);
    checks++; if (k !== 5000 || dn !== 0) begin errors++; $display("FAIL retarget_pre: plots=%0d dones=%0d, expected 5000 0", k, dn); end
    checks++; if (fc !== 2) begin errors++; $display("FAIL retarget_restart: cycle %0d, expected 2", fc); end
    checks++; if (n !== 19200 || dc !== 19202 || ob !== 0) begin errors++; $display("FAIL retarget_sweep: plots=%0d done=%0d ob=%0d, expected 19200 19202 0", n, dc, ob); end
  endtask
  task automatic test_glyph();
    int bad, fgc, px, py;
    bit inw, edg;
    checks++; if (cbuf[0] !== EDGE_COL) begin errors++; $display("FAIL glyph_corner: %b, expected %b", cbuf[0], EDGE_COL); end
    checks++; if (cbuf[pidx(54, 56)] !== 3'b100 || cbuf[pidx(53, 56)] !== 3'b000) begin errors++; $display("FAIL glyph_g: %b %b, expected 100 000", cbuf[pidx(54, 56)], cbuf[pidx(53, 56)]); end
    checks++; if (cbuf[pidx(59, 59)] !== 3'b100) begin errors++; $display("FAIL glyph_a: %b, expected 100", cbuf[pidx(59, 59)]); end
    checks++; if (cbuf[pidx(65, 56)] !== 3'b100 || cbuf[pidx(66, 56)] !== 3'b000) begin errors++; $display("FAIL glyph_m: %b %b, expected 100 000", cbuf[pidx(65, 56)], cbuf[pidx(66, 56)]); end
    checks++; if (cbuf[pidx(84, 62)] !== 3'b100 || cbuf[pidx(83, 62)] !== 3'b000) begin errors++; $display("FAIL glyph_o: %b %b, expected 100 000", cbuf[pidx(84, 62)], cbuf[pidx(83, 62)]); end
    checks++; if (cbuf[pidx(104, 56)] !== 3'b100 || cbuf[pidx(105, 56)] !== 3'b000) begin errors++; $display("FAIL glyph_r: %b %b, expected 100 000", cbuf[pidx(104, 56)], cbuf[pidx(105, 56)]); end
    checks++; if (cbuf[pidx(48, 52)] !== 3'b000) begin errors++; $display("FAIL glyph_blank_row: %b, expected 000", cbuf[pidx(48, 52)]); end
    bad = 0;
    fgc = 0;
    for (int k = 0; k < 19200; k++) begin
      px = k % 160;
      py = k / 160;
      inw = px >= 48 && px < 112 && py >= 52 && py < 68;
      edg = px == 0 || px == 159 || py == 0 || py == 119;
      if (inw) begin
        if (cbuf[k] === 3'b100) fgc++;
        else if (cbuf[k] !== 3'b000) bad++;
      end else if (edg) begin
        if (cbuf[k] !== EDGE_COL) bad++;
      end else if (cbuf[k] !== 3'b000) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL glyph_background: %0d stray pixels, expected 0", bad); end
    checks++; if (fgc !== 137) begin errors++; $display("FAIL glyph_fg_count: %0d, expected 137", fgc); end
  endtask
  task automatic test_abort();
    int k, dn, bad;
    idle_flags();
    show_title = 1'b1;
    count_plots(100, k, dn);
    show_title = 1'b0;
    tick();
    checks++; if (k !== 100) begin errors++; $display("FAIL abort_reach: %0d plots, expected 100", k); end
    checks++; if (plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_stop: plot=%b busy=%b, expected 0 0", plot, busy); end
    bad = 0;
    repeat (30) begin
      if (done || plot) bad++;
      tick();
    end
    checks++; if (bad !== 0 || dn !== 0) begin errors++; $display("FAIL abort_no_done: %0d active cycles, expected 0", bad + dn); end
  endtask
  task automatic test_reset_mid();
    int k, dn, n, fc, dc, ob;
    idle_flags();
    show_title = 1'b1;
    count_plots(300, k, dn);
    rst = 1'b1;
    tick();
    checks++; if ({x, y, colour, plot, busy, done} !== 21'd0) begin errors++; $display("FAIL rstmid_outputs: x=%0d y=%0d c=%b p/b/d=%b%b%b, expected all 0", x, y, colour, plot, busy, done); end
    rst = 1'b0;
    capture_sweep(10, n, fc, dc, ob);
    checks++; if (fc !== 2 || n !== 10 || ob !== 0 || dc !== -1) begin errors++; $display("FAIL rstmid_restart: first=%0d plots=%0d ob=%0d done=%0d, expected 2 10 0 -1", fc, n, ob, dc); end
    idle_flags();
  endtask
  initial begin
    test_reset();
    test_title();
    test_black();
    test_retarget();
    test_glyph();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/splash_painter.md
# splash_painter

Framebuffer painter that sits between the splash-screen state machine and the VGA adapter. It consumes the level flags `showTitle`, `showGameOver` and `drawBlack`, and for each newly selected image sweeps the whole 160x120 framebuffer once. It emits one `(x, y, colour, plot)` write per cycle, then pulses `done`. It is the drawing end of the splash-screen interface: the state machine chooses what to show, this block puts it on screen.

## Interface
- `WIDTH`, 160, framebuffer columns
- `HEIGHT`, 120, framebuffer rows
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `showTitle`  in  1  level request: title image
- `showGameOver`  in  1  level request: game-over image
- `drawBlack`  in  1  level request: all-black screen
- `x`  out  8  pixel column to VGA adapter, registered
- `y`  out  7  pixel row to VGA adapter, registered
- `colour`  out  3  RGB pixel colour, registered
- `plot`  out  1  write strobe; `x`/`y`/`colour` valid when high
- `busy`  out  1  high while a sweep is in progress
- `done`  out  1  one-cycle pulse after the last pixel of a completed sweep

## Operation
- **Image select, combinational, priority order:**
  - `drawBlack` selects IMG_BLACK.
  - Otherwise `showGameOver` selects IMG_GAMEOVER.
  - Otherwise `showTitle` selects IMG_TITLE.
  - With no flag asserted, the select is IMG_NONE.
- `sel_q` holds the previous cycle's select. A *trigger* occurs when select != `sel_q` and select != IMG_NONE.
- **FSM states:** IDLE, SWEEP, FINISH.
  - **IDLE:** on trigger, latch the select into `img`, clear the counters to (0,0), and go to SWEEP.
  - **SWEEP:** one pixel per cycle in raster order, x fastest. At x == WIDTH-1 the column counter wraps to 0 and y increments. After pixel (WIDTH-1, HEIGHT-1), go to FINISH.
  - **FINISH:** `done` = 1 for one cycle, then go to IDLE.
- **Mid-sweep select change:**
  - New select is not IMG_NONE (a trigger): restart SWEEP at (0,0) with the new `img`. No `done` for the aborted sweep.
  - New select is IMG_NONE: abort to IDLE, `plot` drops, no `done`.
- A level held constant never retriggers. Exactly one sweep per image entry.
- **Colour rules:**
  - IMG_BLACK: every pixel is 3'b000.
  - Inside the text window (x 48..111, y 52..67): colour is the foreground colour if the glyph bit is 1, otherwise 3'b000. Foreground is 3'b010 for IMG_TITLE and 3'b100 for IMG_GAMEOVER.
  - Outside the text window: 3'b000.
- **Glyph address:** `{img[0], y-52 (4 b), x-48 (6 b)}`. Subtraction is performed on zero-extended coordinates and is used only inside the window.

## Timing
- **Reset:** all outputs are 0 (`x`, `y`, `colour`, `plot`, `busy`, `done`). State is IDLE and `sel_q` is IMG_NONE.
- **Start:** a trigger sampled at edge N gives `plot` = 1 with (0,0) valid after edge N+1.
- **Sweep length:** pixel k (k = y*WIDTH + x) is valid after edge N+1+k. The last pixel is valid after edge N+WIDTH*HEIGHT.
- **Completion:** `done` = 1 and `plot` = 0 after edge N+WIDTH*HEIGHT+1. `busy` is high exactly while `plot` is high.
- **Glyph lookup:** combinational from the next-pixel counters and registered with `x`/`y`, so colour and coordinates align with zero skew.
- **Reset mid-sweep:** returns to IDLE on the next edge with `plot` = 0 and no `done`.

## Configuration
- `SPLASH_BORDER_EN`
  - **Defined:** for IMG_TITLE and IMG_GAMEOVER, pixels with x == 0, x == WIDTH-1, y == 0 or y == HEIGHT-1 are 3'b111. This overrides the background. IMG_BLACK is unaffected.
  - **Undefined:** edge pixels follow the normal colour rules. Sweep timing is identical in both builds.

## Structure
- **`splash_pkg`** holds:
  - The image-select enum (2 bits): IMG_NONE, IMG_TITLE, IMG_GAMEOVER, IMG_BLACK.
  - Colour constants: COL_BLACK, COL_TITLE, COL_GAMEOVER, COL_BORDER.
  - Text-window origin and size constants: 48, 52, 64, 16.
- **Sub-module `splash_glyph_rom`:** a combinational 2048x1 bitmap, with 11-bit address in and 1-bit pixel out. It holds the "SNAKE" and "GAME OVER" text bitmaps.

## Test plan
- **Reset, then title:** `rst` high for 2 cycles, then `showTitle` = 1. Expect first `plot` 1 cycle later at (0,0), exactly 19200 plots, last at (159,119), then a single `done`, then `plot` 0 thereafter while `showTitle` stays high.
- **Black priority:** `drawBlack` = 1 and `showGameOver` = 1 together. Expect every plotted colour to be 3'b000, with 19200 plots.
- **Retarget mid-sweep:** title sweep running; at pixel 5000 assert `showGameOver`. Expect the next plot at (0,0) with game-over colours, no `done` for the title sweep, and `done` after 19200 further plots.
- **Abort:** at pixel 100 drop all flags. Expect `plot` and `busy` = 0 the next cycle and no `done`.
- **Glyph check:** game-over sweep. Pixel (0,0) is 3'b000 (3'b111 with `SPLASH_BORDER_EN`). Pixels in window 48..111 x 52..67 are 3'b100 or 3'b000, matching the `splash_glyph_rom` model; all pixels outside the window and off the border are 3'b000.
- **Reset mid-sweep:** `rst` at pixel 300. Expect all outputs 0 the next cycle; with `showTitle` still high after reset release, a fresh sweep starts from (0,0).
